// File: rtl/fsm_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fsm_rr_arbiter: IDLE/GRANT/RELEASE round-robin arbiter with a        |
// | registered shared data bus. Optional hold watchdog: FSM_ARB_TIMEOUT_EN|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fsm_rr_arbiter #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        done,
   input  logic [N_REQ*DATA_W-1:0] din,
   output logic [N_REQ-1:0]        gnt,
   output logic                    gnt_valid,
   output logic [DATA_W-1:0]       dout,
   output logic [7:0]              grant_cnt,
   output logic                    timeout
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] GNT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2) begin : g_param_check
      $error("fsm_rr_arbiter: unsupported N_REQ or MAX_HOLD");
   end

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [DATA_W-1:0]  dout_q, dout_d;
   logic [7:0]         grant_cnt_q, grant_cnt_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic [DATA_W-1:0]  pick_data;
   logic [DATA_W-1:0]  own_data;
   logic               rel;

`ifdef FSM_ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic               timeout_q, timeout_d;
`endif

   // Search starts one past the last winner, so the previous owner ranks lowest.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = last_q;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!pick_found && req[(int'(last_q) + i) % N_REQ]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'((int'(last_q) + i) % N_REQ);
         end
      end
   end

   assign pick_data = din[int'(pick_idx) * DATA_W +: DATA_W];
   assign own_data  = din[int'(owner_q) * DATA_W +: DATA_W];

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      gnt_d       = gnt_q;
      dout_d      = dout_q;
      grant_cnt_d = grant_cnt_q;
      rel         = 1'b0;
`ifdef FSM_ARB_TIMEOUT_EN
      hold_cnt_d  = hold_cnt_q;
      timeout_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            gnt_d  = '0;
            dout_d = '0;
            if (pick_found) begin
               owner_d     = pick_idx;
               gnt_d       = GNT_ONE << pick_idx;
               dout_d      = pick_data;
               grant_cnt_d = grant_cnt_q + 8'd1;
               state_d     = ST_GRANT;
`ifdef FSM_ARB_TIMEOUT_EN
               hold_cnt_d  = '0;
`endif
            end
         end
         ST_GRANT: begin
            dout_d = own_data;
`ifdef FSM_ARB_TIMEOUT_EN
            if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
`endif
            // done outranks withdrawal, which outranks the watchdog.
            if (done[owner_q]) begin
               rel = 1'b1;
            end else if (!req[owner_q]) begin
               rel = 1'b1;
`ifdef FSM_ARB_TIMEOUT_EN
            end else if (hold_cnt_q == HOLD_LAST) begin
               rel       = 1'b1;
               timeout_d = 1'b1;
`endif
            end
            if (rel) begin
               gnt_d   = '0;
               dout_d  = '0;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            gnt_d   = '0;
            dout_d  = '0;
            last_d  = owner_q;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            dout_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_q      <= LAST_RST;
         owner_q     <= '0;
         gnt_q       <= '0;
         dout_q      <= '0;
         grant_cnt_q <= '0;
`ifdef FSM_ARB_TIMEOUT_EN
         hold_cnt_q  <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         gnt_q       <= gnt_d;
         dout_q      <= dout_d;
         grant_cnt_q <= grant_cnt_d;
`ifdef FSM_ARB_TIMEOUT_EN
         hold_cnt_q  <= hold_cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign dout      = dout_q;
   assign grant_cnt = grant_cnt_q;
`ifdef FSM_ARB_TIMEOUT_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fsm_rr_arbiter: vector table plus hand sequences for the arbiter. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fsm_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  done;
   logic [31:0] din;
   logic [3:0]  gnt;
   logic        gnt_valid;
   logic [7:0]  dout;
   logic [7:0]  grant_cnt;
   logic        timeout;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic [7:0] dout;
      logic [7:0] cnt;
      logic       to;
   } exp_t;

   typedef struct packed {
      logic        rst_n;
      logic [3:0]  req;
      logic [3:0]  done;
      logic [31:0] din;
      exp_t        exp;
   } vec_t;

   vec_t tbl[$];
   exp_t sb_q[$];

   localparam logic [31:0] D0 = 32'h4433_2211;
   localparam logic [31:0] DA = 32'h44A5_2211;
   localparam logic [31:0] D5 = 32'h445A_2211;

   fsm_rr_arbiter #(
      .N_REQ   (4),
      .DATA_W  (8),
      .MAX_HOLD(4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .done     (done),
      .din      (din),
      .gnt      (gnt),
      .gnt_valid(gnt_valid),
      .dout     (dout),
      .grant_cnt(grant_cnt),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                      input logic [31:0] d, input logic [3:0] g, input logic [7:0] o,
                      input logic [7:0] c, input logic t);
      vec_t v;
      v.rst_n = r; v.req = rq; v.done = dn; v.din = d;
      v.exp.gnt = g; v.exp.dout = o; v.exp.cnt = c; v.exp.to = t;
      tbl.push_back(v);
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic step(input string tag, input logic r, input logic [3:0] rq,
                       input logic [3:0] dn, input logic [31:0] d, input exp_t e);
      exp_t x;
      rst_n = r; req = rq; done = dn; din = d;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      chk({tag, " gnt"},       {28'd0, gnt},       {28'd0, x.gnt});
      chk({tag, " gnt_valid"}, {31'd0, gnt_valid}, {31'd0, (x.gnt != 4'd0)});
      chk({tag, " dout"},      {24'd0, dout},      {24'd0, x.dout});
      chk({tag, " grant_cnt"}, {24'd0, grant_cnt}, {24'd0, x.cnt});
      chk({tag, " timeout"},   {31'd0, timeout},   {31'd0, x.to});
   endtask

   function automatic exp_t mk(input logic [3:0] g, input logic [7:0] o,
                               input logic [7:0] c, input logic t);
      exp_t e;
      e.gnt = g; e.dout = o; e.cnt = c; e.to = t;
      return e;
   endfunction

   initial begin
      logic [7:0] cnt;
      rst_n = 1'b0; req = '0; done = '0; din = D0;

      // reset with all requests pending, then requester 0 wins first
      add(0, 4'hF, 4'h0, D0, 4'h0, 8'h00, 8'd0, 0);
      add(0, 4'hF, 4'h0, D0, 4'h0, 8'h00, 8'd0, 0);
      add(1, 4'hF, 4'h0, D0, 4'h1, 8'h11, 8'd1, 0);
      add(1, 4'hF, 4'h1, D0, 4'h0, 8'h00, 8'd1, 0);
      add(1, 4'h0, 4'h0, D0, 4'h0, 8'h00, 8'd1, 0);
      // single requester 2, data tracking, foreign done ignored
      add(1, 4'h4, 4'h0, DA, 4'h4, 8'hA5, 8'd2, 0);
      add(1, 4'h4, 4'h0, D5, 4'h4, 8'h5A, 8'd2, 0);
      add(1, 4'h4, 4'hB, DA, 4'h4, 8'hA5, 8'd2, 0);
      add(1, 4'h4, 4'h4, DA, 4'h0, 8'h00, 8'd2, 0);
      add(1, 4'h0, 4'h0, DA, 4'h0, 8'h00, 8'd2, 0);
      // round robin between 0 and 2
      add(1, 4'h5, 4'h0, D0, 4'h1, 8'h11, 8'd3, 0);
      add(1, 4'h5, 4'h0, D0, 4'h1, 8'h11, 8'd3, 0);
      add(1, 4'h5, 4'h1, D0, 4'h0, 8'h00, 8'd3, 0);
      add(1, 4'h5, 4'h0, D0, 4'h0, 8'h00, 8'd3, 0);
      add(1, 4'h5, 4'h0, D0, 4'h4, 8'h33, 8'd4, 0);
      add(1, 4'h5, 4'h0, D0, 4'h4, 8'h33, 8'd4, 0);
      add(1, 4'h5, 4'h4, D0, 4'h0, 8'h00, 8'd4, 0);
      add(1, 4'h5, 4'h0, D0, 4'h0, 8'h00, 8'd4, 0);
      add(1, 4'h5, 4'h0, D0, 4'h1, 8'h11, 8'd5, 0);
      add(1, 4'h5, 4'h0, D0, 4'h1, 8'h11, 8'd5, 0);
      add(1, 4'h5, 4'h1, D0, 4'h0, 8'h00, 8'd5, 0);
      add(1, 4'h5, 4'h0, D0, 4'h0, 8'h00, 8'd5, 0);
      add(1, 4'h5, 4'h0, D0, 4'h4, 8'h33, 8'd6, 0);
      add(1, 4'h5, 4'h4, D0, 4'h0, 8'h00, 8'd6, 0);
      add(1, 4'h0, 4'h0, D0, 4'h0, 8'h00, 8'd6, 0);
      // withdrawal of requester 1, then requester 3
      add(1, 4'h2, 4'h0, D0, 4'h2, 8'h22, 8'd7, 0);
      add(1, 4'hA, 4'h0, D0, 4'h2, 8'h22, 8'd7, 0);
      add(1, 4'h8, 4'h0, D0, 4'h0, 8'h00, 8'd7, 0);
      add(1, 4'h8, 4'h0, D0, 4'h0, 8'h00, 8'd7, 0);
      add(1, 4'h8, 4'h0, D0, 4'h8, 8'h44, 8'd8, 0);
      // reset mid-grant restores requester 0 priority
      add(0, 4'h8, 4'h0, D0, 4'h0, 8'h00, 8'd0, 0);
      add(1, 4'h9, 4'h0, D0, 4'h1, 8'h11, 8'd1, 0);
      add(1, 4'h9, 4'h1, D0, 4'h0, 8'h00, 8'd1, 0);
      add(1, 4'h9, 4'h0, D0, 4'h0, 8'h00, 8'd1, 0);
      add(1, 4'h9, 4'h0, D0, 4'h8, 8'h44, 8'd2, 0);
      add(1, 4'h0, 4'h0, D0, 4'h0, 8'h00, 8'd2, 0);
      add(1, 4'h0, 4'h0, D0, 4'h0, 8'h00, 8'd2, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].req, tbl[i].done,
              tbl[i].din, tbl[i].exp);
      end

      // grant counter wraps from 255 to 0
      cnt = 8'd2;
      for (int k = 0; k < 254; k++) begin
         cnt = cnt + 8'd1;
         step("wrap grant", 1, 4'h1, 4'h0, D0, mk(4'h1, 8'h11, cnt, 0));
         step("wrap drop",  1, 4'h0, 4'h0, D0, mk(4'h0, 8'h00, cnt, 0));
         step("wrap idle",  1, 4'h0, 4'h0, D0, mk(4'h0, 8'h00, cnt, 0));
      end
      chk("wrap final cnt", {24'd0, grant_cnt}, 32'd0);

`ifdef FSM_ARB_TIMEOUT_EN
      // forced release after 4 held cycles, re-grant two cycles later
      step("to g1", 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd1, 0));
      step("to g2", 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd1, 0));
      step("to g3", 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd1, 0));
      step("to g4", 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd1, 0));
      step("to rel", 1, 4'h2, 4'h0, D0, mk(4'h0, 8'h00, 8'd1, 1));
      step("to idle", 1, 4'h2, 4'h0, D0, mk(4'h0, 8'h00, 8'd1, 0));
      step("to regnt", 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd2, 0));
      step("to h2", 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd2, 0));
      step("to h3", 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd2, 0));
      step("to h4", 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd2, 0));
      // done coincides with expiry: exit credited to done, no pulse
      step("to done", 1, 4'h2, 4'h2, D0, mk(4'h0, 8'h00, 8'd2, 0));
      step("to end", 1, 4'h0, 4'h0, D0, mk(4'h0, 8'h00, 8'd2, 0));
`else
      step("hold g1", 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd1, 0));
      for (int k = 0; k < 24; k++) begin
         step($sformatf("hold c%0d", k), 1, 4'h2, 4'h0, D0, mk(4'h2, 8'h22, 8'd1, 0));
      end
      step("hold drop", 1, 4'h0, 4'h0, D0, mk(4'h0, 8'h00, 8'd1, 0));
      step("hold end",  1, 4'h0, 4'h0, D0, mk(4'h0, 8'h00, 8'd1, 0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
